// File: rtl/park_drain_scheduler_pkg.sv
// Shared types and width helpers for the park drain scheduler.
package park_drain_scheduler_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAlloc,
      StStream,
      StFree
   } drain_state_e;

   // UID = {row, col}, row in the upper bits.
   function automatic int unsigned calc_uid_w(int unsigned rows, int unsigned cols);
      return $clog2(rows) + $clog2(cols);
   endfunction

   // Beat counts run 0..max_beats inclusive.
   function automatic int unsigned calc_nbeats_w(int unsigned max_beats);
      return $clog2(max_beats + 1);
   endfunction

   localparam int unsigned DefUidW = calc_uid_w(4, 4);
   typedef logic [DefUidW-1:0] uid_t;

   function automatic int unsigned uid_row(int unsigned uid, int unsigned col_w);
      return uid >> col_w;
   endfunction

   function automatic int unsigned uid_col(int unsigned uid, int unsigned col_w);
      return uid & ((32'd1 << col_w) - 32'd1);
   endfunction

endpackage

// File: rtl/park_drain_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant.
module park_drain_scheduler_rr_arbiter
   import park_drain_scheduler_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req_i,
   input  logic [IdxW-1:0] last_i,
   output logic [N-1:0]    gnt_o,
   output logic            any_o
);

   logic [IdxW-1:0] idx;
   logic            found;

   // Walk the requesters in rotated order and grant the first one found.
   always_comb begin
      gnt_o = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 1; i <= N; i++) begin
         idx = IdxW'((32'(last_i) + i) % N);
         if (req_i[idx] && !found) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/park_drain_scheduler.sv
// Drains committed bursts from response_park onto the master R channel,
// in order per original-ID row and round-robin across rows.
module park_drain_scheduler
   import park_drain_scheduler_pkg::*;
#(
   parameter int unsigned NUM_ROWS   = 4,
   parameter int unsigned NUM_COLS   = 4,
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned RESP_WIDTH = 2,
   parameter int unsigned MAX_BEATS  = 32,
   parameter int unsigned ID_WIDTH   = 8,
   localparam int unsigned UID_W     = calc_uid_w(NUM_ROWS, NUM_COLS),
   localparam int unsigned NBEATS_W  = calc_nbeats_w(MAX_BEATS)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            commit_vld,
   input  logic [UID_W-1:0]                commit_uid,
   output logic                            alloc_req,
   output logic [UID_W-1:0]                alloc_uid,
   input  logic                            alloc_gnt,
   input  logic [RESP_WIDTH-1:0]           pk_resp,
   input  logic [NBEATS_W-1:0]             pk_nbeats,
   input  logic [MAX_BEATS*DATA_WIDTH-1:0] pk_payload,
   output logic                            free_req,
   output logic [UID_W-1:0]                free_uid,
   input  logic                            free_ack,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [DATA_WIDTH-1:0]           m_data,
   output logic [RESP_WIDTH-1:0]           m_resp,
   output logic                            m_last,
   output logic [ID_WIDTH-1:0]             m_id,
   output logic                            uid_release,
   output logic [UID_W-1:0]                uid_rel_id,
   output logic                            busy
);

   localparam int unsigned ROW_W    = $clog2(NUM_ROWS);
   localparam int unsigned COL_W    = $clog2(NUM_COLS);
   localparam int unsigned NUM_UIDS = NUM_ROWS * NUM_COLS;
   localparam int unsigned BIDX_W   = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

   drain_state_e                         state_q, state_d;
   logic [NUM_UIDS-1:0]                  ready_q, ready_d;
   logic [NUM_ROWS-1:0][COL_W-1:0]       head_col_q, head_col_d;
   logic [ROW_W-1:0]                     rr_q, rr_d;
   logic [UID_W-1:0]                     cur_uid_q, cur_uid_d;
   logic [RESP_WIDTH-1:0]                resp_q;
   logic [NBEATS_W-1:0]                  nbeats_q;
   logic [NBEATS_W-1:0]                  beat_idx_q, beat_idx_d;
   logic [MAX_BEATS-1:0][DATA_WIDTH-1:0] payload_q;
   logic                                 rel_q;
   logic [UID_W-1:0]                     rel_id_q;

   logic [NUM_ROWS-1:0] elig;
   logic [NUM_ROWS-1:0] gnt_oh;
   logic                any_elig;
   logic [ROW_W-1:0]    win_row;
   logic [ROW_W-1:0]    cur_row;
   logic                cap_en;
   logic                free_done;
   logic                last_beat;

   assign cur_row   = ROW_W'(uid_row(32'(cur_uid_q), COL_W));
   assign last_beat = (beat_idx_q == nbeats_q - NBEATS_W'(1));

   // A row is eligible only when its head-of-line slot holds a committed burst.
   always_comb begin
      elig = '0;
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
         elig[r] = ready_q[{ROW_W'(r), head_col_q[r]}];
      end
   end

   park_drain_scheduler_rr_arbiter #(
      .N (NUM_ROWS)
   ) u_rr_arbiter (
      .req_i  (elig),
      .last_i (rr_q),
      .gnt_o  (gnt_oh),
      .any_o  (any_elig)
   );

   // One-hot grant to row index.
   always_comb begin
      win_row = '0;
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
         if (gnt_oh[r]) win_row = ROW_W'(r);
      end
   end

   // Drain FSM next state and all handshake outputs; outputs are zero outside their state.
   always_comb begin
      state_d    = state_q;
      cur_uid_d  = cur_uid_q;
      rr_d       = rr_q;
      beat_idx_d = beat_idx_q;
      cap_en     = 1'b0;
      free_done  = 1'b0;
      alloc_req  = 1'b0;
      alloc_uid  = '0;
      free_req   = 1'b0;
      free_uid   = '0;
      m_valid    = 1'b0;
      m_data     = '0;
      m_resp     = '0;
      m_last     = 1'b0;
      m_id       = '0;
      unique case (state_q)
         StIdle: begin
            if (any_elig) begin
               state_d   = StAlloc;
               cur_uid_d = {win_row, head_col_q[win_row]};
               rr_d      = win_row;
            end
         end
         StAlloc: begin
            alloc_req = 1'b1;
            alloc_uid = cur_uid_q;
            if (alloc_gnt) begin
               cap_en     = 1'b1;
               beat_idx_d = '0;
               state_d    = StStream;
            end
         end
         StStream: begin
            m_valid = 1'b1;
            m_data  = payload_q[beat_idx_q[BIDX_W-1:0]];
            m_resp  = resp_q;
            m_last  = last_beat;
            m_id    = ID_WIDTH'(cur_row);
            if (m_ready) begin
               if (last_beat) state_d = StFree;
               else           beat_idx_d = beat_idx_q + NBEATS_W'(1);
            end
         end
         StFree: begin
            free_req = 1'b1;
            free_uid = cur_uid_q;
            if (free_ack) begin
               free_done = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Ready bitmap and per-row in-order column pointers; a commit on another bit still lands.
   always_comb begin
      ready_d    = ready_q;
      head_col_d = head_col_q;
      if (free_done) begin
         ready_d[cur_uid_q]  = 1'b0;
         head_col_d[cur_row] = (head_col_q[cur_row] == COL_W'(NUM_COLS - 1)) ? '0 :
                               head_col_q[cur_row] + COL_W'(1);
      end
      if (commit_vld) ready_d[commit_uid] = 1'b1;
   end

   // Control state with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         ready_q    <= '0;
         head_col_q <= '0;
         rr_q       <= '0;
         cur_uid_q  <= '0;
         resp_q     <= '0;
         nbeats_q   <= '0;
         beat_idx_q <= '0;
         rel_q      <= 1'b0;
         rel_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         head_col_q <= head_col_d;
         rr_q       <= rr_d;
         cur_uid_q  <= cur_uid_d;
         beat_idx_q <= beat_idx_d;
         rel_q      <= free_done;
         if (free_done) rel_id_q <= cur_uid_q;
         if (cap_en) begin
            resp_q   <= pk_resp;
            // A zero-beat burst is still sent as one beat.
            nbeats_q <= (pk_nbeats == '0) ? NBEATS_W'(1) : pk_nbeats;
         end
      end
   end

   // Payload is only visible through m_data while streaming, so it carries no reset.
   always_ff @(posedge clk) begin
      if (cap_en) payload_q <= pk_payload;
   end

   assign busy        = (state_q != StIdle);
   assign uid_release = rel_q;
   assign uid_rel_id  = rel_id_q;

   a_commit_dup: assert property (@(posedge clk) disable iff (!rst)
      commit_vld |-> !ready_q[commit_uid]);
   a_nbeats_zero: assert property (@(posedge clk) disable iff (!rst)
      (state_q == StAlloc && alloc_gnt) |-> (pk_nbeats != '0));
   a_req_excl: assert property (@(posedge clk) disable iff (!rst)
      !(alloc_req && free_req));

endmodule
